// File: rtl/arm_pkg.sv
// arm_pkg: shared SRAM controller state type, SRAM bus widths and default base address
package arm_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} sram_state_t;
   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;
   localparam int SRAM_WORD_W = SRAM_AW - 1;
   localparam int DEFAULT_BASE_ADDR = 1024;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: per-phase wait counter, loads WAIT_CYCLES-1 and counts down to zero
// Ports: clk, rst_n (async, active low), load (reload to WAIT_CYCLES-1),
//        dec (count down, saturating at 0), zero (count is 0)
module sram_wait_counter #(
   parameter int WAIT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   logic [CW-1:0] count_q, count_d;
   always_comb
      count_d = load ? CW'(WAIT_CYCLES - 1) : (dec && count_q != '0) ? count_q - 1'b1 : count_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count_q <= '0;
      else count_q <= count_d;
   assign zero = count_q == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage accesses into two timed half-word phases on a 16-bit SRAM
// Ports: clk, rst_n (async, active low); rd_en/wr_en/address/write_data request from MEM stage;
//        read_data load result, ready (pipeline freeze = ~ready);
//        sram_addr/sram_dq_out/sram_dq_oe/sram_we_n drive the SRAM, sram_dq_in returns its data
module sram_controller
   import arm_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);
   sram_state_t state_q, state_d;
   logic [SRAM_WORD_W-1:0] word_q, word_d;
   logic [31:0] data_q, data_d, rdata_q, rdata_d, diff;
   logic wr_q, wr_d, load, dec, zero, req, phase, hi;
   logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
   logic oe_q, oe_d, we_n_q, we_n_d;
   logic unused_bits;
   assign req = rd_en | wr_en;
   // byte offset from the SRAM base; bits above the word field wrap away
   assign diff = address - 32'(BASE_ADDR);
   assign unused_bits = ^{diff[31:SRAM_WORD_W+2], diff[1:0]};
   sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk(clk), .rst_n(rst_n), .load(load), .dec(dec), .zero(zero)
   );
   always_comb begin
      state_d = state_q;
      word_d = word_q;
      data_d = data_q;
      wr_d = wr_q;
      rdata_d = rdata_q;
      load = 1'b0;
      dec = 1'b0;
      case (state_q)
         S_IDLE: if (req) begin
            word_d = diff[SRAM_WORD_W+1:2];
            data_d = write_data;
            wr_d = wr_en;
            load = 1'b1;
            state_d = S_LOW;
         end
         S_LOW: if (zero) begin
            state_d = S_HIGH;
            load = 1'b1;
            if (!wr_q) rdata_d[15:0] = sram_dq_in;
         end else dec = 1'b1;
         S_HIGH: if (zero) begin
            state_d = S_DONE;
            if (!wr_q) rdata_d[31:16] = sram_dq_in;
         end else dec = 1'b1;
         default: state_d = S_IDLE;
      endcase
      // SRAM pins are registered from the state being entered so they are stable for the whole phase
      phase = state_d == S_LOW || state_d == S_HIGH;
      hi = state_d == S_HIGH;
      sram_addr_d = phase ? {word_d, hi} : sram_addr_q;
      dq_out_d = phase ? (hi ? data_d[31:16] : data_d[15:0]) : dq_out_q;
      oe_d = phase && wr_d;
      we_n_d = !(phase && wr_d);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         word_q <= '0;
         data_q <= '0;
         wr_q <= 1'b0;
         rdata_q <= '0;
         sram_addr_q <= '0;
         dq_out_q <= '0;
         oe_q <= 1'b0;
         we_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         word_q <= word_d;
         data_q <= data_d;
         wr_q <= wr_d;
         rdata_q <= rdata_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q <= dq_out_d;
         oe_q <= oe_d;
         we_n_q <= we_n_d;
      end
   assign ready = (state_q == S_IDLE && !req) || state_q == S_DONE;
   assign read_data = rdata_q;
   assign sram_addr = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe = oe_q;
   assign sram_we_n = we_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller at WAIT_CYCLES 3 and 1
module tb_sram_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rd_en = 1'b0, wr_en = 1'b0, sel1 = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [31:0] rd3, rd1;
   logic rdy3, rdy1, oe3, oe1, we3, we1;
   logic [17:0] a3, a1;
   logic [15:0] dq3, dq1, dq3_in;
   logic [15:0] mem [0:63];
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) u3 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(rd3), .ready(rdy3), .sram_addr(a3),
      .sram_dq_out(dq3), .sram_dq_oe(oe3), .sram_dq_in(dq3_in), .sram_we_n(we3)
   );
   sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) u1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(rd1), .ready(rdy1), .sram_addr(a1),
      .sram_dq_out(dq1), .sram_dq_oe(oe1), .sram_dq_in(16'h0000), .sram_we_n(we1)
   );
   assign dq3_in = mem[a3[5:0]];
   always @(posedge clk) if (!we3) mem[a3[5:0]] = dq3;
   logic [31:0] o_rd;
   logic [17:0] o_addr;
   logic [15:0] o_dq;
   logic o_ready, o_oe, o_we_n;
   assign o_rd = sel1 ? rd1 : rd3;
   assign o_addr = sel1 ? a1 : a3;
   assign o_dq = sel1 ? dq1 : dq3;
   assign o_ready = sel1 ? rdy1 : rdy3;
   assign o_oe = sel1 ? oe1 : oe3;
   assign o_we_n = sel1 ? we1 : we3;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one full access on the selected instance, checking every phase cycle and DONE
   task automatic access(input bit s1, input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [16:0] word, input logic [31:0] exp_rd);
      int wc;
      logic hi;
      wc = s1 ? 1 : 3;
      sel1 = s1;
      @(negedge clk);
      wr_en = w; rd_en = r; address = a; write_data = d;
      #1;
      check("req_ready", 32'(o_ready), 32'd0);
      check("idle_we_n", 32'(o_we_n), 32'd1);
      for (int c = 1; c <= 2 * wc; c++) begin
         hi = c > wc;
         @(negedge clk); #1;
         check($sformatf("addr_c%0d", c), 32'(o_addr), 32'({word, hi}));
         check($sformatf("we_n_c%0d", c), 32'(o_we_n), 32'(!w));
         check($sformatf("oe_c%0d", c), 32'(o_oe), 32'(w));
         check($sformatf("ready_c%0d", c), 32'(o_ready), 32'd0);
         if (w) check($sformatf("dq_c%0d", c), 32'(o_dq), 32'(hi ? d[31:16] : d[15:0]));
      end
      @(negedge clk); #1;
      check("done_ready", 32'(o_ready), 32'd1);
      check("done_we_n", 32'(o_we_n), 32'd1);
      check("done_rdata", o_rd, exp_rd);
      wr_en = 1'b0; rd_en = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[6] = 16'hA5A5;
      mem[7] = 16'h5A5A;
      repeat (2) @(negedge clk);
      #1;
      check("rst_rdata", rd3, 32'h0);
      check("rst_ready", 32'(rdy3), 32'd1);
      check("rst_we_n", 32'(we3), 32'd1);
      check("rst_oe", 32'(oe3), 32'd0);
      check("rst_addr", 32'(a3), 32'd0);
      check("rst_dq", 32'(dq3), 32'd0);
      rst_n = 1'b1;
      access(0, 1, 0, 32'd1024, 32'hDEADBEEF, 17'd0, 32'h0);
      access(0, 0, 1, 32'd1024, 32'h0, 17'd0, 32'hDEADBEEF);
      access(0, 0, 1, 32'd1036, 32'h0, 17'd3, 32'h5A5AA5A5);
      access(0, 0, 1, 32'd1039, 32'h0, 17'd3, 32'h5A5AA5A5);
      access(0, 1, 1, 32'd1024, 32'h12345678, 17'd0, 32'h5A5AA5A5);
      access(0, 0, 1, 32'd1024, 32'h0, 17'd0, 32'h12345678);
      sel1 = 1'b0;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
      repeat (5) @(negedge clk);
      #1;
      check("pre_rst_we_n", 32'(we3), 32'd0);
      check("pre_rst_addr", 32'(a3), 32'd1);
      wr_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_we_n", 32'(we3), 32'd1);
      check("mid_rst_ready", 32'(rdy3), 32'd1);
      check("mid_rst_oe", 32'(oe3), 32'd0);
      check("mid_rst_rdata", rd3, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 0, 1, 32'd1036, 32'h0, 17'd3, 32'h5A5AA5A5);
      access(0, 0, 1, 32'd0, 32'h0, 17'h1FF00, 32'hCAFEF00D);
      repeat (10) @(negedge clk);
      access(1, 1, 0, 32'd1024, 32'h11112222, 17'd0, 32'h0);
      access(1, 1, 0, 32'd1028, 32'h33334444, 17'd1, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit data-memory accesses from the MEM stage onto a 16-bit asynchronous SRAM. Each access is split into two half-word phases, and each phase is held for a programmable number of wait cycles. While an access is in flight, `ready` drops so the hazard/freeze logic stalls the pipeline. The block sits between the MEM stage (driven by the decoded `mem_read`/`mem_write`) and the external SRAM pins.

## Interface
- `WAIT_CYCLES`, 3: clock cycles each half-word phase is held on the SRAM bus; legal values are ≥1.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rd_en` input 1: MEM-stage read request (a load).
- `wr_en` input 1: MEM-stage write request (a store).
- `address` input 32: byte address of the access.
- `write_data` input 32: store data.
- `read_data` output 32: load result; valid while `ready`=1 in DONE.
- `ready` output 1: 0 while an access is pending or in progress; pipeline freeze = ~`ready`.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_out` output 16: data driven toward the SRAM.
- `sram_dq_oe` output 1: tri-state enable for `sram_dq_out`.
- `sram_dq_in` input 16: data returned from the SRAM.
- `sram_we_n` output 1: SRAM write strobe, active low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: if `wr_en`|`rd_en`, latch `address`, `write_data` and op type (write if `wr_en`, else read), load the wait counter with WAIT_CYCLES-1, and go to LOW.
- Simultaneous `rd_en`&`wr_en`: the write wins. No read is performed.
- LOW: drive the lower half-word. When the counter reaches 0, go to HIGH and reload the counter. On a read, capture `sram_dq_in` into `read_data[15:0]` on the exit edge.
- HIGH: same as LOW for the upper half-word, then go to DONE. On a read, capture `sram_dq_in` into `read_data[31:16]` on the exit edge.
- DONE: one cycle, then IDLE unconditionally.
- Address mapping:
  - word = (`address` − BASE_ADDR) >> 2, truncated to 17 bits; out-of-range addresses wrap modulo 2^17.
  - `address[1:0]` is ignored.
  - `sram_addr` = {word, 0} in LOW and {word, 1} in HIGH.
- Write phases: `sram_we_n`=0 and `sram_dq_oe`=1. `sram_dq_out` = latched data[15:0] in LOW and [31:16] in HIGH.
- Read phases, IDLE and DONE: `sram_we_n`=1, `sram_dq_oe`=0.
- `ready` = (IDLE & ~(`rd_en`|`wr_en`)) | DONE. This is combinational from state and request.
- `read_data` holds its value until the next read capture. Writes do not alter it.
- Request inputs are ignored outside IDLE. The requester holds them stable until `ready`=1.

## Timing
- Request sampled in IDLE at cycle 0, with `ready`=0 in that same cycle.
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W = WAIT_CYCLES.
- DONE is at cycle 2W+1, with `ready`=1 and `read_data` valid. Total stall is 2W+1 cycles.
- IDLE is at cycle 2W+2. A new request there starts immediately, so back-to-back accesses have no extra bubble.
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, counter 0. `ready`=1 while no request is present.
- Reset asserted mid-access: the FSM returns to IDLE immediately (asynchronously), and the write strobe is released at once. The partial write is not completed or retried.
- Minimum W=1 gives a 3-cycle stall.
- All SRAM-side outputs decode from registered state and latched operands, so they are glitch-free across a phase.

## Structure
- Shared package `arm_pkg`:
  - state enum `sram_state_t`
  - SRAM address and data width constants (18, 16)
  - default BASE_ADDR
- Sub-module `sram_wait_counter`:
  - load and decrement behaviour
  - `zero` flag
  - width clog2(WAIT_CYCLES)
  - reset to 0
- FSM, operand latches and address mapping live in `sram_controller`.

## Test plan
- W=3, write 0xDEADBEEF to 1024:
  - `sram_addr`=0 with `sram_dq_out`=0xBEEF and `sram_we_n`=0 for cycles 1–3.
  - `sram_addr`=1 with `sram_dq_out`=0xDEAD for cycles 4–6.
  - `ready`=1 at cycle 7.
- Read 1024 back with an SRAM model: `read_data`=0xDEADBEEF at cycle 7, `sram_dq_oe`=0 throughout.
- Read 1036: `sram_addr` 6 then 7. `address` 1039 maps to the same word.
- `rd_en`=`wr_en`=1 at 1024 with data 0x12345678: a write occurs and `read_data` is unchanged.
- Assert `rst_n`=0 during HIGH of a write: `sram_we_n`=1 and `ready`=1 immediately. After release, a fresh read completes normally.
- W=1, two back-to-back writes: each stalls 3 cycles, and the second LOW begins the cycle after the first IDLE sample.
